// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// handshake timing constants common to the subtractor and the future adder.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // done is a single-cycle pulse that follows the last bit slice
    localparam int unsigned DONE_PULSE_CYCLES = 1;
    localparam int unsigned DONE_EXTRA_CYCLES = 1;

    // Edges from the accepting edge to the edge that samples done
    function automatic int unsigned op_latency(input int unsigned width);
        return width + DONE_EXTRA_CYCLES;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Full subtractor built from two half subtractors, plus the half-subtractor
// cell itself. Purely combinational; one instance serves every bit slice.
module HS (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module FS_usingHS (
    input  logic a,
    input  logic b,
    input  logic BIn,
    output logic D,
    output logic BOut
);
    logic d1;
    logic b1;
    logic b2;

    HS u_hs1 (.a(a),  .b(b),   .d(d1), .bout(b1));
    HS u_hs2 (.a(d1), .b(BIn), .d(D),  .bout(b2));

    // A borrow out of either stage means the full slice borrowed
    assign BOut = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = a - b - BIn, LSB first, one bit per clock,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             BIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             BOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic             d_bit;
    logic             borrow_n;
    logic             accept;

    FS_usingHS u_fs (
        .a   (sh_a[0]),
        .b   (sh_b[0]),
        .BIn (borrow),
        .D   (d_bit),
        .BOut(borrow_n)
    );

    // start only counts when no operation is in flight
    assign accept = start && (state == IDLE || state == DONE);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                sh_a   <= a;
                sh_b   <= b;
                borrow <= BIn;
                cnt    <= '0;
            end else if (state == RUN) begin
                // Result fills from the MSB so bit 0 lands at D[0] after WIDTH shifts
                res    <= {d_bit, res[WIDTH-1:1]};
                sh_a   <= sh_a >> 1;
                sh_b   <= sh_b >> 1;
                borrow <= borrow_n;
                if (cnt != LAST) cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign D    = res;
    assign BOut = borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=16 instances,
// scoreboard queues filled at acceptance and drained at each done pulse.
module tb_serial_subtractor;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start8  = 1'b0;
    logic        start16 = 1'b0;
    logic [15:0] a       = '0;
    logic [15:0] b       = '0;
    logic        bin     = 1'b0;

    logic        busy8, done8, bout8;
    logic [7:0]  d8;
    logic        busy16, done16, bout16;
    logic [15:0] d16;

    int errors = 0;
    int checks = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic [16:0] last_exp8  = '0;
    logic [16:0] last_exp16 = '0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a[7:0]), .b(b[7:0]), .BIn(bin),
        .busy(busy8), .done(done8), .D(d8), .BOut(bout8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .BIn(bin),
        .busy(busy16), .done(done16), .D(d16), .BOut(bout16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is taken at the following posedge.
    task automatic launch(input bit w16, input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        a   = aa;
        b   = bb;
        bin = bi;
        if (w16) start16 = 1'b1;
        else     start8  = 1'b1;
        @(posedge clk);
        if (w16) q16.push_back({1'b0, aa} - {1'b0, bb} - 17'(bi));
        else     q8.push_back({1'b0, aa[7:0]} - {1'b0, bb[7:0]} - 9'(bi));
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        bin = 1'($urandom);
    endtask

    // Walks the run from the negedge after acceptance (k = edges since accept)
    // and returns at the negedge where done is high. inject >= 0 raises a
    // stray start with fresh operands at that point of the run.
    task automatic expect_done(input bit w16, input int inject, input string tag);
        int          w;
        bit          seen;
        logic        dn;
        logic        bz;
        logic [16:0] exp;
        logic [16:0] got;
        w    = w16 ? 16 : 8;
        seen = 1'b0;
        for (int k = 0; k <= w + 4 && !seen; k++) begin
            dn = w16 ? done16 : done8;
            bz = w16 ? busy16 : busy8;
            if (dn === 1'b1) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(k + 1), 32'(w + 1));
                got = w16 ? {bout16, d16} : {8'b0, bout8, d8};
                if (w16) begin
                    exp = (q16.size() > 0) ? q16.pop_front() : 'x;
                    last_exp16 = exp;
                end else begin
                    exp = (q8.size() > 0) ? {8'b0, q8.pop_front()} : 'x;
                    last_exp8 = exp;
                end
                check({tag, " result"}, 32'(got), 32'(exp));
            end else begin
                if (k < w) check({tag, " busy"}, 32'(bz), 32'd1);
                if (k == inject) begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    bin = 1'($urandom);
                    if (w16) start16 = 1'b1;
                    else     start8  = 1'b1;
                end else if (k == inject + 1) begin
                    start8  = 1'b0;
                    start16 = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!seen) begin
            check({tag, " timeout"}, 32'(w16 ? done16 : done8), 32'd1);
            if (w16 && q16.size() > 0) void'(q16.pop_front());
            if (!w16 && q8.size() > 0) void'(q8.pop_front());
        end
    endtask

    // One cycle after done: pulse is over and the result is held.
    task automatic idle_check(input bit w16, input string tag);
        @(negedge clk);
        if (w16) begin
            check({tag, " done low"}, 32'(done16), 32'd0);
            check({tag, " busy low"}, 32'(busy16), 32'd0);
            check({tag, " held"}, 32'({bout16, d16}), 32'(last_exp16));
        end else begin
            check({tag, " done low"}, 32'(done8), 32'd0);
            check({tag, " busy low"}, 32'(busy8), 32'd0);
            check({tag, " held"}, 32'({bout8, d8}), 32'(last_exp8[8:0]));
        end
    endtask

    initial begin
        int stray_done;

        repeat (2) @(negedge clk);
        check("rst busy8",  32'(busy8),  32'd0);
        check("rst done8",  32'(done8),  32'd0);
        check("rst D8",     32'(d8),     32'd0);
        check("rst BOut8",  32'(bout8),  32'd0);
        check("rst busy16", 32'(busy16), 32'd0);
        check("rst D16",    32'(d16),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(0, 16'd100, 16'd37, 1'b0);
        expect_done(0, -1, "100-37");
        idle_check(0, "100-37");

        launch(0, 16'd5, 16'd10, 1'b0);
        expect_done(0, -1, "5-10");
        launch(0, 16'd0, 16'd0, 1'b1);
        expect_done(0, -1, "0-0-1");
        launch(0, 16'd255, 16'd255, 1'b0);
        expect_done(0, -1, "255-255");
        launch(0, 16'd255, 16'd0, 1'b1);
        expect_done(0, -1, "255-0-1");
        idle_check(0, "255-0-1");

        // Stray start at cycle 3 of RUN must not disturb the operation
        launch(0, 16'd200, 16'd50, 1'b0);
        expect_done(0, 2, "start ignored");
        idle_check(0, "start ignored");

        // Back-to-back: new start in the DONE cycle
        launch(0, 16'd9, 16'd2, 1'b0);
        expect_done(0, -1, "pre-chain");
        launch(0, 16'd7, 16'd3, 1'b0);
        check("chain busy", 32'(busy8), 32'd1);
        expect_done(0, -1, "7-3 chained");

        // Reset in the middle of RUN aborts without a done pulse
        launch(0, 16'hAA, 16'h11, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", 32'(busy8), 32'd0);
        check("midrst done", 32'(done8), 32'd0);
        check("midrst D",    32'(d8),    32'd0);
        check("midrst BOut", 32'(bout8), 32'd0);
        rst_n = 1'b1;
        q8.delete();
        stray_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0) stray_done++;
        end
        check("no done after reset", 32'(stray_done), 32'd0);
        launch(0, 16'd50, 16'd20, 1'b1);
        expect_done(0, -1, "post-reset");
        idle_check(0, "post-reset");

        for (int i = 0; i < 1000; i++) begin
            launch(0, 16'($urandom), 16'($urandom), 1'($urandom));
            expect_done(0, -1, "rand8");
        end
        idle_check(0, "rand8");

        launch(1, 16'd5, 16'd10, 1'b0);
        expect_done(1, -1, "w16 5-10");
        launch(1, 16'hFFFF, 16'h0000, 1'b1);
        expect_done(1, -1, "w16 max-0-1");
        for (int i = 0; i < 1000; i++) begin
            launch(1, 16'($urandom), 16'($urandom), 1'($urandom));
            expect_done(1, -1, "rand16");
        end
        idle_check(1, "rand16");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
